// File: rtl/mac4_dot_seq_ctrl_if.sv
// Purpose: command, operand stream, result and MAC-pin bundle for mac4_dot_seq_ctrl.
// Latency: none, wires only.
// Backpressure: in_valid/in_ready on operands, res_valid/res_ready on results.
interface mac4_dot_seq_ctrl_if #(
  parameter int CNT_W = 8
);
  // command from the fabric request logic
  logic             cmd_start;
  logic [CNT_W-1:0] cmd_len;
  logic [5:0]       cmd_out_sel;
  logic             cmd_rnd;
  logic             cmd_sat;
  logic             cmd_tc;
  logic             cmd_abort;
  // operand/coefficient stream
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_oper;
  logic [3:0]       in_coef;
  // result port
  logic             res_valid;
  logic             res_ready;
  logic [3:0]       res_data;
  logic             busy;
  // MAC slice control pins
  logic [3:0]       mac_oper_data;
  logic [3:0]       mac_coef_data;
  logic             mac_clk_en;
  logic             mac_acc_clear;
  logic             mac_acc_rnd;
  logic             mac_acc_sat;
  logic [5:0]       mac_out_sel;
  logic             mac_tc;
  logic [3:0]       mac_out;

  // sequencer side
  modport slave (
    input  cmd_start, cmd_len, cmd_out_sel, cmd_rnd, cmd_sat, cmd_tc, cmd_abort,
    input  in_valid, in_oper, in_coef, res_ready, mac_out,
    output in_ready, res_valid, res_data, busy,
    output mac_oper_data, mac_coef_data, mac_clk_en, mac_acc_clear, mac_acc_rnd,
    output mac_acc_sat, mac_out_sel, mac_tc
  );

  // requester + MAC side
  modport master (
    output cmd_start, cmd_len, cmd_out_sel, cmd_rnd, cmd_sat, cmd_tc, cmd_abort,
    output in_valid, in_oper, in_coef, res_ready, mac_out,
    input  in_ready, res_valid, res_data, busy,
    input  mac_oper_data, mac_coef_data, mac_clk_en, mac_acc_clear, mac_acc_rnd,
    input  mac_acc_sat, mac_out_sel, mac_tc
  );
endinterface

// File: rtl/mac4_dot_seq_ctrl.sv
// Purpose: sequences one 4-bit MAC slice through a dot product (optional MAC4_SEQ_STALL_CNT_EN adds stall_cnt).
// Latency: res_valid rises on the second edge counting the final accept edge; len=0 takes ZERO+CAPT.
// Backpressure: in_ready only in ACC; result held in HOLD until res_ready; cmd_abort overrides both.
module mac4_dot_seq_ctrl #(
  parameter int CNT_W       = 8,
  parameter int OUT_SEL_MAX = 16
) (
  input  logic              MAC_ACC_CLK,
  input  logic              acc_ff_rstn,
  mac4_dot_seq_ctrl_if.slave bus
`ifdef MAC4_SEQ_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ZERO = 3'd1,
    S_ACC  = 3'd2,
    S_CAPT = 3'd3,
    S_HOLD = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             first_q, first_d;
  logic             rnd_q, rnd_d;
  logic             sat_q, sat_d;
  logic             tc_q, tc_d;
  logic [5:0]       out_sel_q, out_sel_d;
  logic             in_ready_q, in_ready_d;
  logic             res_valid_q, res_valid_d;
  logic [3:0]       res_data_q, res_data_d;
  logic             busy_q, busy_d;

  logic             abort_act;
  logic             in_ready_w;
  logic             accept;
  logic             zero_cyc;
  logic             first_term;
  logic [5:0]       sel_clamped;

  // abort only means something once an operation is running
  assign abort_act  = bus.cmd_abort & (state_q != S_IDLE);
  // abort blocks the accept in the same cycle
  assign in_ready_w = in_ready_q & ~abort_act;
  assign accept     = bus.in_valid & in_ready_w;
  assign zero_cyc   = (state_q == S_ZERO) & ~abort_act;
  // the first term is either the first accept or the lone ZERO cycle
  assign first_term = (accept & first_q) | zero_cyc;
  assign sel_clamped = (bus.cmd_out_sel > 6'(OUT_SEL_MAX)) ? 6'(OUT_SEL_MAX) : bus.cmd_out_sel;

  // MAC pin drive: operands pass through only while streaming
  always_comb begin
    bus.mac_oper_data = '0;
    bus.mac_coef_data = '0;
    if (state_q == S_ACC) begin
      bus.mac_oper_data = bus.in_oper;
      bus.mac_coef_data = bus.in_coef;
    end
    bus.mac_clk_en    = accept | zero_cyc;
    // the MAC favours CLEAR over RND, so only one is ever raised
    bus.mac_acc_clear = first_term & ~rnd_q;
    bus.mac_acc_rnd   = first_term & rnd_q;
  end

  assign bus.mac_acc_sat = sat_q;
  assign bus.mac_out_sel = out_sel_q;
  assign bus.mac_tc      = tc_q;
  assign bus.in_ready    = in_ready_w;
  assign bus.res_valid   = res_valid_q & ~abort_act;
  assign bus.res_data    = res_data_q;
  assign bus.busy        = busy_q;

  // next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    first_d     = first_q;
    rnd_d       = rnd_q;
    sat_d       = sat_q;
    tc_d        = tc_q;
    out_sel_d   = out_sel_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_start) begin
          out_sel_d = sel_clamped;
          rnd_d     = bus.cmd_rnd;
          sat_d     = bus.cmd_sat;
          tc_d      = bus.cmd_tc;
          first_d   = 1'b1;
          cnt_d     = bus.cmd_len;
          state_d   = (bus.cmd_len == '0) ? S_ZERO : S_ACC;
        end
      end
      S_ZERO: begin
        first_d = 1'b0;
        state_d = S_CAPT;
      end
      S_ACC: begin
        if (accept) begin
          first_d = 1'b0;
          cnt_d   = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = S_CAPT;
          end
        end
      end
      S_CAPT: begin
        // accumulator and MAC select register settled on the final accept edge
        res_data_d  = bus.mac_out;
        res_valid_d = 1'b1;
        state_d     = S_HOLD;
      end
      S_HOLD: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort_act) begin
      state_d     = S_IDLE;
      res_valid_d = 1'b0;
      res_data_d  = res_data_q;
    end

    in_ready_d = (state_d == S_ACC);
    busy_d     = (state_d != S_IDLE);
  end

  // FSM and configuration registers
  always_ff @(posedge MAC_ACC_CLK or negedge acc_ff_rstn) begin
    if (!acc_ff_rstn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      first_q     <= 1'b0;
      rnd_q       <= 1'b0;
      sat_q       <= 1'b0;
      tc_q        <= 1'b0;
      out_sel_q   <= '0;
      in_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      first_q     <= first_d;
      rnd_q       <= rnd_d;
      sat_q       <= sat_d;
      tc_q        <= tc_d;
      out_sel_q   <= out_sel_d;
      in_ready_q  <= in_ready_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      busy_q      <= busy_d;
    end
  end

`ifdef MAC4_SEQ_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // count starved ACC cycles, saturating, restarted by each accepted start
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == S_IDLE) && bus.cmd_start) begin
      stall_cnt_d = '0;
    end else if ((state_q == S_ACC) && !bus.in_valid && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // stall counter register
  always_ff @(posedge MAC_ACC_CLK or negedge acc_ff_rstn) begin
    if (!acc_ff_rstn) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mac4_dot_seq_ctrl.sv
// Bench for mac4_dot_seq_ctrl with a behavioural 4-bit MAC slice attached.
module tb_mac4_dot_seq_ctrl;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;

  mac4_dot_seq_ctrl_if #(.CNT_W(8)) bus ();

`ifdef MAC4_SEQ_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  mac4_dot_seq_ctrl #(.CNT_W(8), .OUT_SEL_MAX(16)) dut (
    .MAC_ACC_CLK (clk),
    .acc_ff_rstn (rstn),
    .bus         (bus)
`ifdef MAC4_SEQ_STALL_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural MAC slice ----------------
  logic signed [31:0] m_acc;
  logic [5:0]         m_sel;
  logic               m_sat;
  logic               m_tc;
  logic signed [4:0]  m_a;
  logic signed [4:0]  m_b;
  logic signed [31:0] m_prod;
  logic signed [31:0] m_rc;
  logic signed [31:0] m_shift;
  logic [3:0]         m_out;

  always_comb begin
    m_a    = bus.mac_tc ? {bus.mac_oper_data[3], bus.mac_oper_data} : {1'b0, bus.mac_oper_data};
    m_b    = bus.mac_tc ? {bus.mac_coef_data[3], bus.mac_coef_data} : {1'b0, bus.mac_coef_data};
    m_prod = m_a * m_b;
    m_rc   = (bus.mac_out_sel == 6'd0) ? 32'sd0 : (32'sd1 <<< (bus.mac_out_sel - 6'd1));
  end

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_acc <= 0; m_sel <= 0; m_sat <= 0; m_tc <= 0;
    end else if (bus.mac_clk_en) begin
      m_sel <= bus.mac_out_sel;
      m_sat <= bus.mac_acc_sat;
      m_tc  <= bus.mac_tc;
      if (bus.mac_acc_clear)     m_acc <= m_prod;
      else if (bus.mac_acc_rnd)  m_acc <= m_prod + m_rc;
      else                       m_acc <= m_acc + m_prod;
    end
  end

  always_comb begin
    m_shift = m_acc >>> m_sel;
    if (!m_sat)     m_out = m_shift[3:0];
    else if (m_tc)  m_out = (m_shift > 7) ? 4'h7 : ((m_shift < -8) ? 4'h8 : m_shift[3:0]);
    else            m_out = (m_shift > 15) ? 4'hF : ((m_shift < 0) ? 4'h0 : m_shift[3:0]);
  end
  assign bus.mac_out = m_out;

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_cmd(input logic [7:0] len, input logic [5:0] sel,
                           input logic rnd, input logic sat, input logic tc);
    bus.cmd_len = len; bus.cmd_out_sel = sel;
    bus.cmd_rnd = rnd; bus.cmd_sat = sat; bus.cmd_tc = tc;
    bus.cmd_start = 1'b1;
    tick();
    bus.cmd_start = 1'b0;
  endtask

  // present one pair, wait for acceptance, report MAC pins seen on the accept cycle
  task automatic push(input logic [3:0] op, input logic [3:0] cf,
                      output logic clr, output logic rnd, output logic en, output logic [3:0] mo);
    int n;
    n = 0;
    bus.in_valid = 1'b1; bus.in_oper = op; bus.in_coef = cf;
    #1;
    while (!bus.in_ready && n < 20) begin
      tick(); #1; n++;
    end
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL push_timeout: in_ready=%0b required=1", bus.in_ready);
    end
    clr = bus.mac_acc_clear; rnd = bus.mac_acc_rnd; en = bus.mac_clk_en; mo = bus.mac_oper_data;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_res(output logic [3:0] d);
    int n;
    n = 0;
    #1;
    while (!bus.res_valid && n < 20) begin
      tick(); #1; n++;
    end
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL res_timeout: res_valid=%0b required=1", bus.res_valid);
    end
    d = bus.res_data;
  endtask

  task automatic release_res();
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [25:0] obs;
    rstn = 1'b0;
    #3;
    obs = {bus.busy, bus.in_ready, bus.res_valid, bus.res_data, bus.mac_clk_en, bus.mac_acc_clear,
           bus.mac_acc_rnd, bus.mac_acc_sat, bus.mac_out_sel, bus.mac_tc, bus.mac_oper_data,
           bus.mac_coef_data};
    checks++;
    if (obs !== 26'd0) begin
      errors++; $display("FAIL reset_outputs: got %h required 0", obs);
    end
    tick(); tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic c, r, e;
    logic [3:0] mo, d;
    logic [3:0] exp_r [2];
    exp_r[0] = 4'hA;  // 26 = 0x1A, window [3:0]
    exp_r[1] = 4'hF;  // 26 saturates unsigned 4-bit
    for (int s = 0; s < 2; s++) begin
      start_cmd(8'd3, 6'd0, 1'b0, s[0], 1'b0);
      push(4'd3, 4'd5, c, r, e, mo);
      checks++;
      if ({c, r, e, mo} !== {1'b1, 1'b0, 1'b1, 4'd3}) begin
        errors++; $display("FAIL basic_first_term: clr/rnd/en/oper=%b required 1_0_1_0011", {c, r, e, mo});
      end
      push(4'd2, 4'd2, c, r, e, mo);
      checks++;
      if ({c, r, e} !== 3'b001) begin
        errors++; $display("FAIL basic_second_term: clr/rnd/en=%b required 001", {c, r, e});
      end
      push(4'd1, 4'd7, c, r, e, mo);
      checks++;
      if ({c, r, e} !== 3'b001) begin
        errors++; $display("FAIL basic_third_term: clr/rnd/en=%b required 001", {c, r, e});
      end
      #1;
      checks++;
      if ({bus.res_valid, bus.busy} !== 2'b01) begin
        errors++; $display("FAIL basic_capt_cycle: res_valid/busy=%b required 01", {bus.res_valid, bus.busy});
      end
      tick();
      checks++;
      if ({bus.res_valid, bus.res_data} !== {1'b1, exp_r[s]}) begin
        errors++; $display("FAIL basic_result sat=%0d: valid/data=%b/%h required 1/%h",
                           s, bus.res_valid, bus.res_data, exp_r[s]);
      end
      release_res();
      #1;
      checks++;
      if ({bus.res_valid, bus.busy} !== 2'b00) begin
        errors++; $display("FAIL basic_release: res_valid/busy=%b required 00", {bus.res_valid, bus.busy});
      end
    end
  endtask

  task automatic test_tc_sat();
    logic c, r, e;
    logic [3:0] mo, d;
    start_cmd(8'd2, 6'd0, 1'b0, 1'b1, 1'b1);
    #1;
    checks++;
    if ({bus.mac_tc, bus.mac_acc_sat} !== 2'b11) begin
      errors++; $display("FAIL tc_config: tc/sat=%b required 11", {bus.mac_tc, bus.mac_acc_sat});
    end
    push(4'h8, 4'h8, c, r, e, mo);
    push(4'h8, 4'h8, c, r, e, mo);
    wait_res(d);
    checks++;
    if (d !== 4'h7) begin
      errors++; $display("FAIL tc_pos_saturation: res_data=%h required 7", d);
    end
    release_res();
  endtask

  task automatic test_round();
    logic c, r, e;
    logic [3:0] mo, d;
    start_cmd(8'd1, 6'd2, 1'b1, 1'b0, 1'b0);
    #1;
    checks++;
    if ({bus.mac_acc_rnd, bus.mac_clk_en, bus.mac_out_sel} !== {1'b0, 1'b0, 6'd2}) begin
      errors++; $display("FAIL round_idle_pins: rnd/en/sel=%b/%b/%0d required 0/0/2",
                         bus.mac_acc_rnd, bus.mac_clk_en, bus.mac_out_sel);
    end
    push(4'd3, 4'd1, c, r, e, mo);
    checks++;
    if ({c, r, e} !== 3'b011) begin
      errors++; $display("FAIL round_accept_pins: clr/rnd/en=%b required 011", {c, r, e});
    end
    wait_res(d);
    checks++;
    if (d !== 4'h1) begin
      errors++; $display("FAIL round_result: res_data=%h required 1", d);
    end
    release_res();
  endtask

  task automatic test_zero_len();
    logic [3:0] d;
    start_cmd(8'd0, 6'd40, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if ({bus.mac_clk_en, bus.mac_acc_clear, bus.mac_acc_rnd, bus.mac_oper_data, bus.mac_out_sel}
        !== {1'b1, 1'b1, 1'b0, 4'd0, 6'd16}) begin
      errors++; $display("FAIL zero_cycle_pins: en/clr/rnd/oper/sel=%b/%b/%b/%h/%0d required 1/1/0/0/16",
                         bus.mac_clk_en, bus.mac_acc_clear, bus.mac_acc_rnd, bus.mac_oper_data, bus.mac_out_sel);
    end
    tick();
    wait_res(d);
    checks++;
    if (d !== 4'h0) begin
      errors++; $display("FAIL zero_result: res_data=%h required 0", d);
    end
    bus.cmd_len = 8'd1; bus.cmd_start = 1'b1; bus.res_ready = 1'b1;
    tick();
    bus.cmd_start = 1'b0; bus.res_ready = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.res_valid, bus.in_ready} !== 3'b000) begin
      errors++; $display("FAIL hold_start_ignored: busy/res_valid/in_ready=%b required 000",
                         {bus.busy, bus.res_valid, bus.in_ready});
    end
    tick();
  endtask

  task automatic test_stall_hold();
    logic c, r, e;
    logic [3:0] mo, d;
    logic bad;
    start_cmd(8'd4, 6'd0, 1'b0, 1'b0, 1'b0);
    push(4'd2, 4'd3, c, r, e, mo);
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if ({bus.mac_clk_en, bus.in_ready, bus.busy} !== 3'b011) bad = 1'b1;
      tick();
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++; $display("FAIL stall_no_enable: saw en/in_ready/busy other than 0/1/1, got en=%b", bus.mac_clk_en);
    end
    push(4'd1, 4'd1, c, r, e, mo);
    push(4'd4, 4'd2, c, r, e, mo);
    push(4'd1, 4'd2, c, r, e, mo);
    wait_res(d);
    checks++;
    if (d !== 4'h1) begin  // 6+1+8+2 = 17 = 0x11
      errors++; $display("FAIL stall_result: res_data=%h required 1", d);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({bus.res_valid, bus.res_data} !== 5'b1_0001) begin
        errors++; $display("FAIL hold_stable cyc%0d: valid/data=%b/%h required 1/1", i, bus.res_valid, bus.res_data);
      end
    end
`ifdef MAC4_SEQ_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'd3) begin
      errors++; $display("FAIL stall_cnt: got %0d required 3", stall_cnt);
    end
`endif
    release_res();
  endtask

  task automatic test_abort_reset();
    logic c, r, e;
    logic [3:0] mo, d;
    logic seen;
    logic [11:0] obs;
    start_cmd(8'd3, 6'd0, 1'b0, 1'b0, 1'b0);
    push(4'd5, 4'd5, c, r, e, mo);
    bus.in_valid = 1'b1; bus.in_oper = 4'd5; bus.in_coef = 4'd5; bus.cmd_abort = 1'b1;
    #1;
    checks++;
    if ({bus.in_ready, bus.mac_clk_en} !== 2'b00) begin
      errors++; $display("FAIL abort_same_cycle: in_ready/en=%b required 00", {bus.in_ready, bus.mac_clk_en});
    end
    tick();
    bus.cmd_abort = 1'b0; bus.in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL abort_idle: res_valid/busy went high after abort, got %b/%b", bus.res_valid, bus.busy);
    end
    start_cmd(8'd2, 6'd3, 1'b0, 1'b1, 1'b1);
    push(4'd5, 4'd5, c, r, e, mo);
    rstn = 1'b0;
    #1;
    obs = {bus.busy, bus.in_ready, bus.res_valid, bus.res_data, bus.mac_out_sel[2:0], bus.mac_tc, bus.mac_acc_sat};
    checks++;
    if (obs !== 12'd0) begin
      errors++; $display("FAIL async_reset_mid_acc: got %h required 0", obs);
    end
    tick();
    rstn = 1'b1;
    tick();
    start_cmd(8'd2, 6'd4, 1'b0, 1'b0, 1'b0);
    push(4'd7, 4'd7, c, r, e, mo);
    push(4'd1, 4'd1, c, r, e, mo);
    wait_res(d);
    checks++;
    if (d !== 4'h3) begin  // 50 = 0x32, window [7:4]
      errors++; $display("FAIL post_reset_op: res_data=%h required 3", d);
    end
    release_res();
  endtask

  initial begin
    checks = 0; errors = 0;
    rstn = 1'b0;
    bus.cmd_start = 1'b0; bus.cmd_len = '0; bus.cmd_out_sel = '0;
    bus.cmd_rnd = 1'b0; bus.cmd_sat = 1'b0; bus.cmd_tc = 1'b0; bus.cmd_abort = 1'b0;
    bus.in_valid = 1'b0; bus.in_oper = '0; bus.in_coef = '0; bus.res_ready = 1'b0;
    test_reset();
    test_basic();
    test_tc_sat();
    test_round();
    test_zero_len();
    test_stall_hold();
    test_abort_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac4_dot_seq_ctrl.md
Name: mac4_dot_seq_ctrl

Overview:
Sequencer that drives one 4-bit MAC slice in the math unit through a complete dot-product. It accepts a start command carrying the vector length and output configuration, streams operand/coefficient pairs into the MAC under valid/ready flow control, and issues CLEAR or RND on the first term. It captures the selected 4-bit MAC result and returns it on a valid/ready result port. It sits between the eFPGA fabric request logic and the MAC control pins.

Parameters:
CNT_W, 8, width of the vector-length field; maximum length is 2^CNT_W-1 terms.
OUT_SEL_MAX, 16, highest legal output-select value; larger requests are clamped to this value.

Ports:
MAC_ACC_CLK  in  1  clock; also clocks the MAC slice
acc_ff_rstn  in  1  asynchronous active-low reset; shared with the MAC slice
cmd_start  in  1  start pulse; sampled only in IDLE
cmd_len  in  CNT_W  number of terms
cmd_out_sel  in  6  result bit-window select
cmd_rnd  in  1  round instead of clear on the first term
cmd_sat  in  1  saturate the result
cmd_tc  in  1  two's-complement operands
cmd_abort  in  1  synchronous abort, returns to IDLE
in_valid  in  1  operand pair valid
in_ready  out  1  operand pair accepted this cycle when in_valid is also high
in_oper  in  4  operand
in_coef  in  4  coefficient
res_valid  out  1  result valid
res_ready  in  1  result consumed
res_data  out  4  captured MAC result
busy  out  1  high whenever the FSM is not in IDLE
mac_oper_data  out  4  to the MAC operand input
mac_coef_data  out  4  to the MAC coefficient input
mac_clk_en  out  1  to EFPGA_MATHB_CLK_EN
mac_acc_clear  out  1  to MAC_ACC_CLEAR
mac_acc_rnd  out  1  to MAC_ACC_RND
mac_acc_sat  out  1  to MAC_ACC_SAT
mac_out_sel  out  6  to MAC_OUT_SEL
mac_tc  out  1  to MAC_TC
mac_out  in  4  from MAC_OUT

Behaviour:
- Reset (asynchronous, active-low): state goes to IDLE and all outputs and configuration registers go to 0.
- States: IDLE, ZERO, ACC, CAPT, HOLD.
- IDLE:
  - On cmd_start, latch len, out_sel (clamped to OUT_SEL_MAX), rnd, sat and tc.
  - If len is 0, go to ZERO; otherwise load the remaining-term counter with len and go to ACC.
- ACC:
  - in_ready=1.
  - mac_clk_en = in_valid & in_ready.
  - mac_oper_data/mac_coef_data pass in_oper/in_coef through combinationally in this state and are 0 in every other state.
  - On the first accepted term only: mac_acc_clear = ~rnd and mac_acc_rnd = rnd, gated by the accept. The MAC gives CLEAR priority over RND, so exactly one of the two is asserted.
  - Each accept decrements the counter. The accept that takes the counter to 0 moves the FSM to CAPT.
  - in_valid low is a stall: no MAC enable, state held.
- ZERO: one cycle with mac_clk_en=1, zero operands, and clear/rnd asserted per the latched rnd. The accumulator ends at 0 or at the rounding constant. Next state is CAPT.
- CAPT: mac_clk_en=0. Register mac_out into res_data, set res_valid=1, go to HOLD.
  - Result latency: res_valid rises 2 edges after the last accepted term. The MAC output-select register and the accumulator both update on the final accept edge.
- HOLD: res_valid stays high and res_data stable until res_ready=1. On that edge res_valid drops and the FSM returns to IDLE. A cmd_start on the same edge is ignored; a new start is accepted from IDLE on the following cycle.
- mac_out_sel, mac_tc and mac_acc_sat drive the latched configuration, constant for the whole operation. They keep their last values in IDLE until the next start.
- cmd_start while busy is ignored.
- cmd_abort (any non-IDLE state): go to IDLE next edge. in_ready, mac_clk_en and res_valid go low that cycle. Abort takes priority over accept and over res_ready.
- Asynchronous reset mid-operation: same effect as abort, applied immediately.

Optional Feature:
MAC4_SEQ_STALL_CNT_EN:
- Defined: adds output stall_cnt[15:0], counting ACC cycles with in_valid=0.
  - Saturates at 16'hFFFF.
  - Cleared on an accepted cmd_start.
  - Reset value 0.
- Undefined: port and logic are absent; behaviour is otherwise identical.

Test Plan:
- len=3, rnd=0, tc=0, out_sel=0, pairs (3,5),(2,2),(1,7) streamed back-to-back -> clear on the first term only, accumulator 26, res_data=4'hA; with sat=1 -> res_data=4'hF.
- tc=1, sat=1, len=2, pairs (-8,-8),(-8,-8), out_sel=0 -> accumulator 128, res_data=4'h7 (positive saturation).
- rnd=1, out_sel=2, len=1, pair (3,1) -> mac_acc_rnd pulses with the accept and mac_acc_clear stays 0; accumulator 3+2=5, res_data=4'h1.
- len=4 with in_valid low for 3 cycles between terms, then res_ready held low for 5 cycles -> no extra accumulation; res_valid and res_data stable until res_ready.
- len=0 -> one ZERO cycle, res_data=0; cmd_start asserted during HOLD is ignored.
- cmd_abort mid-ACC, then acc_ff_rstn pulsed mid-ACC on a second run -> IDLE, res_valid never asserted, all outputs 0 after reset; the next operation computes correctly.
